// File: rtl/boot_loader.sv
// Serial boot loader: sync 0xA5, word count, big-endian words, 8-bit additive checksum into instruction RAM.
// One RAM write cycle per word (rx_ready low then, source holds); once loaded, the CPU owns the RAM port combinationally.
module boot_loader #(
    parameter int addr_width = 8,
    parameter int data_width = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic [addr_width-1:0] cpu_w_addr,
    input  logic [data_width-1:0] cpu_din,
    input  logic                  cpu_w_en,
    output logic [addr_width-1:0] ram_w_addr,
    output logic [data_width-1:0] ram_din,
    output logic                  ram_w_en,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_err
);

    typedef enum logic [2:0] {SYNC, LEN, HI, LO, WRITE, CSUM, DONE} state_t;

    state_t                state, state_nxt;
    logic [7:0]            n_words;
    logic [7:0]            csum;
    logic [addr_width-1:0] word_addr;
    logic [data_width-1:0] word;
    logic                  accept;
    logic                  last_word;

    assign accept = rx_valid & rx_ready;

    // 8-bit wrap turns a count of 0 into last index 255, i.e. 256 words
    assign last_word = (word_addr == addr_width'(n_words - 8'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        rx_ready   = 1'b1;
        ram_w_en   = 1'b0;
        ram_w_addr = word_addr;
        ram_din    = word;
        case (state)
            SYNC, DONE: begin
                if (accept && rx_data == 8'hA5) begin
                    state_nxt = LEN;
                end
                if (state == DONE) begin
                    ram_w_en   = cpu_w_en;
                    ram_w_addr = cpu_w_addr;
                    ram_din    = cpu_din;
                end
            end
            LEN: if (accept) state_nxt = HI;
            HI:  if (accept) state_nxt = LO;
            LO:  if (accept) state_nxt = WRITE;
            WRITE: begin
                rx_ready  = 1'b0;
                ram_w_en  = 1'b1;
                state_nxt = last_word ? CSUM : HI;
            end
            CSUM: begin
                if (accept) begin
                    state_nxt = (rx_data == csum) ? DONE : SYNC;
                end
            end
            default: state_nxt = SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_words   <= '0;
            csum      <= '0;
            word_addr <= '0;
            word      <= '0;
            cpu_hold  <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            case (state)
                SYNC, DONE: begin
                    if (accept && rx_data == 8'hA5) begin
                        cpu_hold  <= 1'b1;
                        load_done <= 1'b0;
                        load_err  <= 1'b0;
                    end
                end
                LEN: begin
                    if (accept) begin
                        n_words   <= rx_data;
                        word_addr <= '0;
                        csum      <= '0;
                    end
                end
                HI: begin
                    if (accept) begin
                        word[15:8] <= rx_data;
                        csum       <= csum + rx_data;
                    end
                end
                LO: begin
                    if (accept) begin
                        word[7:0] <= rx_data;
                        csum      <= csum + rx_data;
                    end
                end
                WRITE: begin
                    if (!last_word) begin
                        word_addr <= word_addr + 1'b1;
                    end
                end
                CSUM: begin
                    if (accept) begin
                        if (rx_data == csum) begin
                            load_done <= 1'b1;
                            cpu_hold  <= 1'b0;
                        end else begin
                            load_err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: table-driven image loads with a write scoreboard, plus wrap, abort and arbitration sequences.
module tb_boot_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  cpu_w_addr;
    logic [15:0] cpu_din;
    logic        cpu_w_en;
    logic [7:0]  ram_w_addr;
    logic [15:0] ram_din;
    logic        ram_w_en;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    boot_loader #(.addr_width(8), .data_width(16)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .cpu_w_addr(cpu_w_addr), .cpu_din(cpu_din), .cpu_w_en(cpu_w_en),
        .ram_w_addr(ram_w_addr), .ram_din(ram_din), .ram_w_en(ram_w_en),
        .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int stalls = 0;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;
    wr_t exp_q[$];
    wr_t mon_e;

    typedef struct {
        logic [7:0]  b;
        bit          push;
        logic [7:0]  addr;
        logic [15:0] word;
        bit          hold;
        bit          done;
        bit          err;
        bit          rdy;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Internal-load writes must match the scoreboard; DONE-state writes belong to the CPU.
    always @(negedge clk) begin
        if (rx_valid && !rx_ready) stalls++;
        if (ram_w_en === 1'b1 && load_done !== 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", ram_w_addr, ram_din);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", {24'd0, ram_w_addr}, {24'd0, mon_e.addr});
                chk("wr_data", {16'd0, ram_din}, {16'd0, mon_e.data});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit taken;
        taken    = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 50 && !taken; i++) begin
            @(negedge clk);
            taken = rx_ready;
            @(posedge clk);
            #1;
        end
        if (!taken) begin
            total++;
            bad++;
            $display("FAIL send_timeout: byte %0h not accepted within 50 cycles, expected acceptance", b);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        rx_valid = 1'b0;
        cpu_w_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        stalls = 0;
    endtask

    task automatic run_table(input bit bad_cs);
        vec_t v;
        for (int i = 0; i < 9; i++) begin
            v = tbl[i];
            if (bad_cs && i == 8) begin
                v.b    = 8'h15;
                v.hold = 1'b1;
                v.done = 1'b0;
                v.err  = 1'b1;
            end
            if (v.push) exp_q.push_back({v.addr, v.word});
            send_byte(v.b);
            chk($sformatf("tbl%0d_hold", i), {31'd0, cpu_hold}, {31'd0, v.hold});
            chk($sformatf("tbl%0d_done", i), {31'd0, load_done}, {31'd0, v.done});
            chk($sformatf("tbl%0d_err", i), {31'd0, load_err}, {31'd0, v.err});
            chk($sformatf("tbl%0d_rdy", i), {31'd0, rx_ready}, {31'd0, v.rdy});
        end
        rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", exp_q.size(), 0);
    endtask

    initial begin
        automatic logic [7:0] sum = 8'h00;
        automatic logic [7:0] hi;
        automatic logic [7:0] lo;

        //          b      push addr   word      hold done err rdy
        tbl[0] = '{8'h00, 0, 8'h00, 16'h0000, 1, 0, 0, 1};
        tbl[1] = '{8'hFF, 0, 8'h00, 16'h0000, 1, 0, 0, 1};
        tbl[2] = '{8'hA5, 0, 8'h00, 16'h0000, 1, 0, 0, 1};
        tbl[3] = '{8'h02, 0, 8'h00, 16'h0000, 1, 0, 0, 1};
        tbl[4] = '{8'h12, 0, 8'h00, 16'h0000, 1, 0, 0, 1};
        tbl[5] = '{8'h34, 1, 8'h00, 16'h1234, 1, 0, 0, 0};
        tbl[6] = '{8'h56, 0, 8'h00, 16'h0000, 1, 0, 0, 1};
        tbl[7] = '{8'h78, 1, 8'h01, 16'h5678, 1, 0, 0, 0};
        tbl[8] = '{8'h14, 0, 8'h00, 16'h0000, 0, 1, 0, 1};

        rx_data    = 8'h00;
        cpu_w_addr = 8'h00;
        cpu_din    = 16'h0000;

        do_reset();
        chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
        chk("rst_done", {31'd0, load_done}, 32'd0);
        chk("rst_err", {31'd0, load_err}, 32'd0);
        chk("rst_rdy", {31'd0, rx_ready}, 32'd1);
        chk("rst_wen", {31'd0, ram_w_en}, 32'd0);

        // good image
        run_table(1'b0);

        // bad checksum, then a fresh sync clears the error
        do_reset();
        run_table(1'b1);
        chk("bad_sync_rdy", {31'd0, rx_ready}, 32'd1);
        send_byte(8'hA5);
        rx_valid = 1'b0;
        chk("bad_resync_err", {31'd0, load_err}, 32'd0);
        chk("bad_resync_hold", {31'd0, cpu_hold}, 32'd1);

        // 256-word image wraps the address; each WRITE cycle stalls the held byte
        do_reset();
        send_byte(8'hA5);
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            hi  = 8'(i);
            lo  = 8'(i) ^ 8'h5A;
            sum = sum + hi + lo;
            send_byte(hi);
            exp_q.push_back({8'(i), hi, lo});
            send_byte(lo);
        end
        send_byte(sum);
        rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("wrap_stalls", stalls, 256);
        chk("wrap_done", {31'd0, load_done}, 32'd1);
        chk("wrap_hold", {31'd0, cpu_hold}, 32'd0);
        chk("wrap_sb_empty", exp_q.size(), 0);

        // reset mid-word: no write, then a full load works
        do_reset();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'hAB);
        rx_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_rdy", {31'd0, rx_ready}, 32'd1);
        chk("abort_hold", {31'd0, cpu_hold}, 32'd1);
        chk("abort_wen", {31'd0, ram_w_en}, 32'd0);
        run_table(1'b0);

        // CPU write port ignored during load, passed straight through in DONE
        do_reset();
        cpu_w_addr = 8'h10;
        cpu_din    = 16'hBEEF;
        cpu_w_en   = 1'b1;
        run_table(1'b0);
        chk("arb_wen", {31'd0, ram_w_en}, 32'd1);
        chk("arb_addr", {24'd0, ram_w_addr}, 32'h10);
        chk("arb_din", {16'd0, ram_din}, 32'hBEEF);
        cpu_w_addr = 8'h22;
        #1;
        chk("arb_addr_comb", {24'd0, ram_w_addr}, 32'h22);
        cpu_w_en = 1'b0;
        #1;
        chk("arb_wen_off", {31'd0, ram_w_en}, 32'd0);
        send_byte(8'h3C);
        chk("done_discard", {31'd0, load_done}, 32'd1);
        send_byte(8'hA5);
        rx_valid = 1'b0;
        chk("restart_done", {31'd0, load_done}, 32'd0);
        chk("restart_hold", {31'd0, cpu_hold}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
